// File: rtl/ledseq_pkg.sv
// Shared types and constants for the LED sequencer.
package ledseq_pkg;

  typedef enum logic [1:0] {
    MODE_CHASE  = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_BINARY = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/led_sequencer_if.sv
// PMOD control inputs and LED outputs of the sequencer; the step line exists only with LEDSEQ_STEP_EN.
interface led_sequencer_if #(
  parameter int N_LEDS = 5
);

  logic [1:0]        mode;
  logic [1:0]        speed;
  logic              dir;
  logic              run;
`ifdef LEDSEQ_STEP_EN
  logic              step;
`endif
  logic [N_LEDS-1:0] led;
  logic              tick;

`ifdef LEDSEQ_STEP_EN
  modport master (output mode, speed, dir, run, step, input led, tick);
  modport slave  (input mode, speed, dir, run, step, output led, tick);
`else
  modport master (output mode, speed, dir, run, input led, tick);
  modport slave  (input mode, speed, dir, run, output led, tick);
`endif

endinterface

// File: rtl/led_sync2.sv
// Multi-bit 2-flop synchroniser for slow asynchronous PMOD levels; bits are not treated as a coherent bus.
module led_sync2
  import ledseq_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [SYNC_STAGES-1:0][W-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/led_sequencer.sv
// Programmable-rate LED pattern generator (chase, bounce, binary, blink) driven by PMOD inputs.
// Define LEDSEQ_STEP_EN to add a single-step input that advances the pattern while run=0.
module led_sequencer
  import ledseq_pkg::*;
#(
  parameter int CLK_HZ  = 12000000,
  parameter int TICK_HZ = 2,
  parameter int N_LEDS  = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  led_sequencer_if.slave io
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CW  = $clog2(DIV);
  localparam int PW  = $clog2(N_LEDS);
  localparam logic [PW-1:0] LAST = PW'(N_LEDS - 1);

  if ((DIV >> 3) < 1) begin : g_div_check
    $error("led_sequencer: CLK_HZ/TICK_HZ must be at least 8");
  end
  if (N_LEDS < 2 || N_LEDS > 16) begin : g_leds_check
    $error("led_sequencer: N_LEDS must be in 2..16");
  end

  logic [5:0]        ctrlSync;
  mode_e             modeS;
  logic [1:0]        speedS;
  logic              dirS;
  logic              runS;
  logic              stepAdv;

  mode_e             modePrev_q;
  logic [CW-1:0]     prescale_q, prescale_d, limit;
  logic [PW-1:0]     pos_q, pos_d;
  logic              bncDir_q, bncDir_d;
  logic [N_LEDS-1:0] bin_q, bin_d;
  logic              blink_q, blink_d;
  logic              tick_q, tick_d;
  logic [N_LEDS-1:0] led_q, led_d;
  logic              modeChange;
  logic              advance;

  led_sync2 #(.W(6)) u_sync_ctrl (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   ({io.mode, io.speed, io.dir, io.run}),
    .q_o   (ctrlSync)
  );

  assign modeS  = mode_e'(ctrlSync[5:4]);
  assign speedS = ctrlSync[3:2];
  assign dirS   = ctrlSync[1];
  assign runS   = ctrlSync[0];

`ifdef LEDSEQ_STEP_EN
  logic stepS;
  logic stepPrev_q;

  led_sync2 #(.W(1)) u_sync_step (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (io.step),
    .q_o   (stepS)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stepPrev_q <= 1'b0;
    end else begin
      stepPrev_q <= stepS;
    end
  end

  assign stepAdv = ~runS & stepS & ~stepPrev_q;
`else
  assign stepAdv = 1'b0;
`endif

  function automatic logic [N_LEDS-1:0] decode(mode_e m, logic [PW-1:0] p,
                                               logic [N_LEDS-1:0] b, logic bl);
    logic [N_LEDS-1:0] one;
    one = N_LEDS'(1);
    case (m)
      MODE_CHASE, MODE_BOUNCE: decode = one << p;
      MODE_BINARY:             decode = b;
      default:                 decode = {N_LEDS{bl}};
    endcase
  endfunction

  // Display follows the mode that owns the current state, so a mode switch never shows stale state decoded the new way.
  always_comb begin
    limit      = CW'((DIV >> speedS) - 1);
    modeChange = (modeS != modePrev_q);
    prescale_d = prescale_q;
    pos_d      = pos_q;
    bncDir_d   = bncDir_q;
    bin_d      = bin_q;
    blink_d    = blink_q;
    tick_d     = 1'b0;
    advance    = 1'b0;
    led_d      = decode(modePrev_q, pos_q, bin_q, blink_q);

    if (modeChange) begin
      prescale_d = '0;
      pos_d      = '0;
      bncDir_d   = 1'b0;
      bin_d      = '0;
      blink_d    = 1'b0;
      led_d      = decode(modeS, '0, '0, 1'b0);
    end else begin
      if (runS) begin
        if (prescale_q >= limit) begin
          prescale_d = '0;
          advance    = 1'b1;
        end else begin
          prescale_d = prescale_q + 1'b1;
        end
      end else begin
        advance = stepAdv;
      end

      if (advance) begin
        tick_d = 1'b1;
        case (modeS)
          MODE_CHASE: begin
            if (dirS) pos_d = (pos_q == '0) ? LAST : pos_q - 1'b1;
            else      pos_d = (pos_q == LAST) ? '0 : pos_q + 1'b1;
          end
          MODE_BOUNCE: begin
            // Direction flips on arrival so each end position is shown exactly once.
            if (!bncDir_q) begin
              pos_d = pos_q + 1'b1;
              if (pos_d == LAST) bncDir_d = 1'b1;
            end else begin
              pos_d = pos_q - 1'b1;
              if (pos_d == '0) bncDir_d = 1'b0;
            end
          end
          MODE_BINARY: bin_d   = dirS ? bin_q - 1'b1 : bin_q + 1'b1;
          default:     blink_d = ~blink_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      modePrev_q <= MODE_CHASE;
      prescale_q <= '0;
      pos_q      <= '0;
      bncDir_q   <= 1'b0;
      bin_q      <= '0;
      blink_q    <= 1'b0;
      tick_q     <= 1'b0;
      led_q      <= N_LEDS'(1);
    end else begin
      modePrev_q <= modeS;
      prescale_q <= prescale_d;
      pos_q      <= pos_d;
      bncDir_q   <= bncDir_d;
      bin_q      <= bin_d;
      blink_q    <= blink_d;
      tick_q     <= tick_d;
      led_q      <= led_d;
    end
  end

  assign io.led  = led_q;
  assign io.tick = tick_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer with a behavioural pattern model; covers LEDSEQ_STEP_EN when defined.
module tb_led_sequencer;

  localparam int CLK_HZ  = 16;
  localparam int TICK_HZ = 2;
  localparam int N       = 5;
  localparam int DIV     = CLK_HZ / TICK_HZ;

  typedef struct {
    int mode;
    int speed;
    bit dir;
    int nTicks;
  } seg_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  // Model state: chase position, binary count and tick count since the last clear.
  int   mPos, mBin, mK, curMode;
  bit   curDir;

  led_sequencer_if #(.N_LEDS(N)) io ();

  led_sequencer #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ),
    .N_LEDS  (N)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] modelLed();
    logic [N-1:0] one;
    int p;
    one = N'(1);
    case (curMode)
      0: return one << mPos;
      1: begin
        p = mK % (2 * (N - 1));
        if (p >= N) p = 2 * (N - 1) - p;
        return one << p;
      end
      2: return N'(mBin);
      default: return (mK % 2 == 1) ? {N{1'b1}} : {N{1'b0}};
    endcase
  endfunction

  function automatic void modelStep();
    mK++;
    mPos = curDir ? (mPos + N - 1) % N : (mPos + 1) % N;
    mBin = curDir ? (mBin + (1 << N) - 1) % (1 << N) : (mBin + 1) % (1 << N);
  endfunction

  function automatic void modelClear();
    mK   = 0;
    mPos = 0;
    mBin = 0;
  endfunction

  task automatic applyStimulus(input logic [1:0] mode, input logic [1:0] speed,
                               input logic dir, input logic run);
    io.mode  = mode;
    io.speed = speed;
    io.dir   = dir;
    io.run   = run;
  endtask

  task automatic test_reset();
    applyStimulus(2'd0, 2'd0, 1'b0, 1'b1);
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (io.led !== 5'b00001) begin
        errors++;
        $display("[TB] FAIL reset_led: got %b want 00001", io.led);
      end
      checks++;
      if (io.tick !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_tick: got %b want 0", io.tick);
      end
    end
    rst_n   = 1'b1;
    curMode = 0;
    curDir  = 1'b0;
    modelClear();
  endtask

  task automatic test_patterns();
    seg_t segs[$];
    int ticks, cyc, lastTick, period, bound;
    logic [N-1:0] expLed;
    segs.push_back(seg_t'{0, 0, 1'b0, 6});
    segs.push_back(seg_t'{0, 1, 1'b1, 6});
    segs.push_back(seg_t'{1, 0, 1'b0, 9});
    segs.push_back(seg_t'{2, 0, 1'b1, 3});
    segs.push_back(seg_t'{2, 3, 1'b1, 5});
    segs.push_back(seg_t'{3, 2, 1'b0, 4});
    for (int i = 0; i < 10; i++) begin
      segs.push_back(seg_t'{int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                            1'($urandom_range(0, 1)), int'($urandom_range(2, 10))});
    end

    foreach (segs[s]) begin
      // Pause, let in-flight ticks land, then change controls while frozen.
      io.run = 1'b0;
      repeat (4) begin
        @(negedge clk);
        if (io.tick === 1'b1) modelStep();
      end
      applyStimulus(2'(segs[s].mode), 2'(segs[s].speed), segs[s].dir, 1'b0);
      curDir = segs[s].dir;
      if (segs[s].mode != curMode) begin
        curMode = segs[s].mode;
        modelClear();
      end
      repeat (6) begin
        @(negedge clk);
        checks++;
        if (io.tick !== 1'b0) begin
          errors++;
          $display("[TB] FAIL pause_tick seg %0d: got %b want 0", s, io.tick);
        end
      end

      expLed   = modelLed();
      io.run   = 1'b1;
      ticks    = 0;
      cyc      = 0;
      lastTick = -1;
      period   = DIV >> segs[s].speed;
      bound    = segs[s].nTicks * DIV + 20;
      while (ticks < segs[s].nTicks && cyc < bound) begin
        @(negedge clk);
        cyc++;
        checks++;
        if (io.led !== expLed) begin
          errors++;
          $display("[TB] FAIL pattern_led seg %0d mode %0d cyc %0d: got %b want %b",
                   s, curMode, cyc, io.led, expLed);
        end
        if (io.tick === 1'b1) begin
          if (lastTick >= 0) begin
            checks++;
            if (cyc - lastTick != period) begin
              errors++;
              $display("[TB] FAIL tick_period seg %0d: got %0d want %0d", s, cyc - lastTick, period);
            end
          end
          lastTick = cyc;
          modelStep();
          expLed = modelLed();
          ticks++;
        end
      end
      checks++;
      if (ticks != segs[s].nTicks) begin
        errors++;
        $display("[TB] FAIL tick_timeout seg %0d: got %0d ticks want %0d", s, ticks, segs[s].nTicks);
      end
      @(negedge clk);
      checks++;
      if (io.led !== expLed) begin
        errors++;
        $display("[TB] FAIL final_led seg %0d: got %b want %b", s, io.led, expLed);
      end
      if (io.tick === 1'b1) modelStep();
    end
  endtask

  task automatic test_mode_switch();
    int cyc;
    applyStimulus(2'd1, 2'd0, 1'b0, 1'b1);
    repeat (6) @(negedge clk);
    applyStimulus(2'd0, 2'd0, 1'b0, 1'b1);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (io.led !== 5'b01000 && cyc < 80);
    checks++;
    if (io.led !== 5'b01000) begin
      errors++;
      $display("[TB] FAIL switch_reach_pos3: got %b want 01000", io.led);
    end

    applyStimulus(2'd3, 2'd0, 1'b0, 1'b1);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (io.led !== 5'b00000 && cyc < 3);
    checks++;
    if (io.led !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL switch_clear_led: got %b want 00000 within 3 cycles", io.led);
    end
    checks++;
    if (io.tick !== 1'b0) begin
      errors++;
      $display("[TB] FAIL switch_clear_tick: got %b want 0", io.tick);
    end

    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (io.tick !== 1'b1 && cyc < 20);
    checks++;
    if (io.tick !== 1'b1 || cyc != DIV) begin
      errors++;
      $display("[TB] FAIL switch_first_tick: got tick=%b after %0d cycles want 1 after %0d", io.tick, cyc, DIV);
    end
    @(negedge clk);
    checks++;
    if (io.led !== 5'b11111) begin
      errors++;
      $display("[TB] FAIL switch_blink_on: got %b want 11111", io.led);
    end
    curMode = 3;
    modelClear();
    modelStep();
  endtask

  task automatic test_freeze();
    int cyc;
    logic [N-1:0] expLed;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (io.tick !== 1'b1 && cyc < 20);
    checks++;
    if (io.tick !== 1'b1) begin
      errors++;
      $display("[TB] FAIL freeze_wait_tick: got %b want 1", io.tick);
    end
    modelStep();
    expLed = modelLed();
    io.run = 1'b0;
    repeat (20) begin
      @(negedge clk);
      checks++;
      if (io.tick !== 1'b0) begin
        errors++;
        $display("[TB] FAIL freeze_tick: got %b want 0", io.tick);
      end
      checks++;
      if (io.led !== expLed) begin
        errors++;
        $display("[TB] FAIL freeze_led: got %b want %b", io.led, expLed);
      end
    end

    io.run = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (io.tick !== 1'b1 && cyc < 20);
    checks++;
    if (io.tick !== 1'b1 || cyc != DIV) begin
      errors++;
      $display("[TB] FAIL resume_tick: got tick=%b after %0d cycles want 1 after %0d", io.tick, cyc, DIV);
    end
    modelStep();
    @(negedge clk);
    checks++;
    if (io.led !== modelLed()) begin
      errors++;
      $display("[TB] FAIL resume_led: got %b want %b", io.led, modelLed());
    end
  endtask

`ifdef LEDSEQ_STEP_EN
  task automatic test_step();
    int tickCount;
    io.run = 1'b0;
    repeat (4) @(negedge clk);
    applyStimulus(2'd1, 2'd0, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    applyStimulus(2'd0, 2'd0, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    curMode = 0;
    curDir  = 1'b0;
    modelClear();
    checks++;
    if (io.led !== 5'b00001) begin
      errors++;
      $display("[TB] FAIL step_start_led: got %b want 00001", io.led);
    end
    tickCount = 0;
    for (int p = 0; p < 3; p++) begin
      io.step = 1'b1;
      repeat (4) begin
        @(negedge clk);
        if (io.tick === 1'b1) begin
          tickCount++;
          modelStep();
        end
      end
      io.step = 1'b0;
      repeat (4) begin
        @(negedge clk);
        if (io.tick === 1'b1) begin
          tickCount++;
          modelStep();
        end
      end
      checks++;
      if (io.led !== (5'b00010 << p)) begin
        errors++;
        $display("[TB] FAIL step_led pulse %0d: got %b want %b", p, io.led, 5'b00010 << p);
      end
    end
    checks++;
    if (tickCount != 3) begin
      errors++;
      $display("[TB] FAIL step_tick_count: got %0d want 3", tickCount);
    end
  endtask
`endif

  task automatic test_reset_abort();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (io.led !== 5'b00001) begin
      errors++;
      $display("[TB] FAIL abort_led: got %b want 00001", io.led);
    end
    checks++;
    if (io.tick !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_tick: got %b want 0", io.tick);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    applyStimulus(2'd0, 2'd0, 1'b0, 1'b0);
`ifdef LEDSEQ_STEP_EN
    io.step = 1'b0;
`endif
    test_reset();
    test_patterns();
    test_mode_switch();
    test_freeze();
`ifdef LEDSEQ_STEP_EN
    test_step();
`endif
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
- Parametrised successor to the board's fixed 4-LED half-second chaser.
- Divides the board clock into a programmable tick and drives N_LEDS outputs in one of four display patterns.
- Pattern, direction, speed and run/pause are selected live from PMOD header inputs.
- Sits at top level between the PMOD pins and the LED pins; no bus interface.

Parameters:
- CLK_HZ, 12000000, input clock frequency in Hz.
- TICK_HZ, 2, base pattern step rate in Hz at speed=0.
- N_LEDS, 5, number of LED outputs; legal range 2..16.

Ports:
- clk  in  1  board clock, CLK_HZ.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  2  pattern select, asynchronous PMOD input.
- speed  in  2  rate multiplier: tick rate = TICK_HZ << speed; asynchronous.
- dir  in  1  0 = up/left-to-right, 1 = reverse; asynchronous.
- run  in  1  1 = advance, 0 = freeze; asynchronous.
- led  out  N_LEDS  registered LED drive, active-high.
- tick  out  1  single-cycle pulse on each pattern step.

Behaviour:
- Synchronisation
  - All of mode, speed, dir and run pass through 2-flop synchronisers (reset to 0) before use.
  - Effective input latency is 2 clk.
- Prescaler
  - DIV = CLK_HZ/TICK_HZ. Width = $clog2(DIV).
  - Limit = (DIV >> speed) - 1. Elaboration error if (DIV >> 3) < 1.
  - Counts 0..limit; on reaching limit it wraps to 0 and asserts tick for exactly 1 cycle. Period is exactly DIV>>speed cycles (no off-by-one).
  - If a speed change leaves count > limit, the next cycle wraps to 0 and ticks.
  - run=0: prescaler and pattern state hold, tick=0, led holds.
- Pattern state: pos (width $clog2(N_LEDS)), bnc_dir (1 bit), bin (N_LEDS bits), blink (1 bit). Each advances on tick.
- Mode 0 CHASE
  - led = one-hot at pos.
  - dir=0: pos increments, wrapping N_LEDS-1 -> 0. dir=1: pos decrements, wrapping 0 -> N_LEDS-1.
- Mode 1 BOUNCE
  - Ping-pong; dir input ignored. Sequence for N_LEDS=5: 0,1,2,3,4,3,2,1,0,1...
  - End positions are shown once, not repeated. bnc_dir flips on the tick that reaches an end.
- Mode 2 BINARY
  - led = bin. dir=0 increments, dir=1 decrements, modulo 2^N_LEDS.
- Mode 3 BLINK
  - led = all-ones when blink=1, all-zeros when blink=0. blink toggles each tick.
- led is registered: it reflects the new state in the cycle after tick.
- Mode change (synchronised value differs from previous cycle)
  - Next cycle clears pos, bin, blink, bnc_dir and the prescaler.
  - Pattern restarts from position 0 in the new mode. No tick is issued in that cycle.
- Simultaneous mode change and tick: the mode-change clear wins and the tick is suppressed.
- Reset (async assert, sync release)
  - prescaler=0, pos=0, bin=0, blink=0, bnc_dir=0, tick=0.
  - led = 'b0..01, i.e. CHASE position 0.
  - Asserting reset mid-pattern aborts immediately.

Optional Feature:
- Macro: LEDSEQ_STEP_EN.
- Defined:
  - Adds input port `step` (1 bit, asynchronous), synchronised plus rising-edge detected.
  - While run=0, each rising edge of step produces one tick and advances the pattern one position; the prescaler stays held.
  - While run=1, step is ignored.
- Undefined: no step port; run=0 is a pure freeze.

Decomposition:
- Package ledseq_pkg:
  - Mode enum: MODE_CHASE=0, MODE_BOUNCE=1, MODE_BINARY=2, MODE_BLINK=3.
  - Synchroniser depth constant SYNC_STAGES=2.
- One sub-module: led_sync2, a parametrised-width 2-flop synchroniser with async active-low reset. Instantiated once for the control inputs, and once more for step when LEDSEQ_STEP_EN is defined.

Test Plan:
- Base configuration for all scenarios: CLK_HZ=16, TICK_HZ=2 (DIV=8), N_LEDS=5.
- Reset, mode=0, run=1, speed=0, dir=0 -> led=00001 during reset; tick every 8 cycles; led steps 00010, 00100, 01000, 10000, 00001.
- mode=1, run=1 -> led positions 0,1,2,3,4,3,2,1,0 over 8 ticks; no repeated end value.
- mode=2, dir=1 from reset -> first tick gives led=11111, second gives 11110; speed=3 -> tick every 1 cycle.
- Switch mode 0->3 mid-pattern with pos=3 -> within 3 cycles led=00000, prescaler=0; next tick led=11111.
- run=0 for 20 cycles -> tick never asserts, led constant; run=1 -> next tick 8 cycles after prescaler resumes from its held count.
- LEDSEQ_STEP_EN defined, run=0, 3 step pulses in CHASE -> led 00001 -> 00010 -> 00100 -> 01000; tick pulses exactly 3 times.
